instr_fetch_unit: RTL and testbench

- Fetch stage feeding the Controller and the operand datapath of the 32-bit RISC-V core.
- Holds the PC and requests instructions from instruction memory over a valid/ready request and response handshake.
- Latches the returned word into an instruction register and presents Opcode plus the decoded register and function fields to the Controller and register file.
- Takes the branch outcome back from the execute side to pick the next PC.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the 32-bit RISC-V core.
// Holds the PC and fetches one word at a time over a valid/ready request and
// response handshake. It latches the word into an instruction register,
// presents the decoded fields, and advances the PC when the instruction retires.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      Opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic            instr_valid,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            req_valid_q, req_valid_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] raw_next_pc;
  logic            take_branch;

  // Next-PC candidates: all sums wrap modulo 2^XLEN, and the low two bits are
  // always forced to zero so that the PC stays word aligned.
  always_comb begin
    seq_pc      = pc_q + XLEN'(4);
    br_target   = pc_q + branch_offset;
    take_branch = branch & branch_taken;
    raw_next_pc = take_branch ? br_target : seq_pc;
  end

  // Next-state logic for the FETCH -> WAIT -> ISSUE loop.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    req_valid_d   = req_valid_q;
    misaligned_d  = misaligned_q;

    case (state_q)
      FETCH: begin
        // The request valid comes up one cycle after entering FETCH from reset.
        // An accept is counted only while the registered valid is asserted.
        req_valid_d = 1'b1;
        if (req_valid_q && imem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end

      WAIT: begin
        req_valid_d = 1'b0;
        if (imem_resp_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        // While stalled, everything holds and the branch inputs are not used.
        if (!stall) begin
          pc_d          = {raw_next_pc[XLEN-1:2], 2'b00};
          if (take_branch && (br_target[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
          end
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
          req_valid_d   = 1'b1;
          state_d       = FETCH;
        end
      end

      default: begin
        state_d       = FETCH;
        instr_d       = NOP_INSTR;
        instr_valid_d = 1'b0;
        req_valid_d   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is asserted asynchronously and
  // released synchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      req_valid_q   <= req_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // The outputs come directly from the registers. The decoded fields are
  // slices of the instruction register.
  always_comb begin
    imem_req_valid = req_valid_q;
    imem_addr      = pc_q;
    pc             = pc_q;
    instr          = instr_q;
    instr_valid    = instr_valid_q;
    misaligned     = misaligned_q;
    Opcode         = instr_q[6:0];
    rd             = instr_q[11:7];
    funct3         = instr_q[14:12];
    rs1            = instr_q[19:15];
    rs2            = instr_q[24:20];
    funct7         = instr_q[31:25];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. It includes a second instance
// whose RESET_PC is set so that the PC wraps across the top of the address space.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        stall, branch, branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] pc, instr;
  logic [6:0]  Opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        instr_valid, misaligned;

  // Signals for the wrap-around instance.
  logic        w_req_valid, w_req_ready, w_resp_valid, w_stall;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
  logic        w_instr_valid, w_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_rdata(imem_rdata), .stall(stall), .branch(branch),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .instr(instr), .Opcode(Opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .instr_valid(instr_valid), .misaligned(misaligned)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_addr(w_addr), .imem_resp_valid(w_resp_valid),
    .imem_rdata(w_rdata), .stall(w_stall), .branch(1'b0),
    .branch_taken(1'b0), .branch_offset(32'h0),
    .pc(w_pc), .instr(w_instr), .Opcode(w_opcode), .rd(w_rd), .funct3(w_funct3),
    .rs1(w_rs1), .rs2(w_rs2), .funct7(w_funct7),
    .instr_valid(w_instr_valid), .misaligned(w_misaligned)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Wait for a request, check its address, accept it, respond one cycle
  // later, and check that the word is held as a valid instruction in ISSUE.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
    int cnt = 0;
    while (!imem_req_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check_eq({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd1);
    check_eq({tag, "_addr"}, imem_addr, exp_addr);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    check_eq({tag, "_valid_in_wait"}, {31'b0, instr_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_rdata      = word;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'hDEAD_BEEF;
    check_eq({tag, "_valid_in_issue"}, {31'b0, instr_valid}, 32'd1);
    check_eq({tag, "_instr"}, instr, word);
  endtask

  // Let the held instruction retire with the given branch outcome.
  task automatic retire(input logic br, input logic tk, input logic [31:0] off);
    stall         = 1'b0;
    branch        = br;
    branch_taken  = tk;
    branch_offset = off;
    @(negedge clk);
    stall         = 1'b1;
    branch        = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
  endtask

  initial begin
    logic [31:0] held_pc, held_instr;
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_rdata = 32'h0; stall = 1'b1; branch = 1'b0; branch_taken = 1'b0;
    branch_offset = 32'h0;
    w_req_ready = 1'b0; w_resp_valid = 1'b0; w_rdata = 32'h0; w_stall = 1'b1;

    // Check the values held during reset.
    repeat (3) @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_misaligned", {31'b0, misaligned}, 32'd0);
    check_eq("rst_opcode", {25'b0, Opcode}, 32'h13);
    reset = 1'b0;

    // R-type word at address 0, then step to 4.
    do_fetch("r0", 32'h0, 32'h0033_0333);
    check_eq("r0_opcode", {25'b0, Opcode}, 32'h33);
    check_eq("r0_rd", {27'b0, rd}, 32'd6);
    check_eq("r0_rs1", {27'b0, rs1}, 32'd6);
    check_eq("r0_rs2", {27'b0, rs2}, 32'd3);
    check_eq("r0_funct3", {29'b0, funct3}, 32'd0);
    retire(1'b0, 1'b0, 32'h0);
    check_eq("r0_next_pc", pc, 32'd4);
    check_eq("r0_nop_after", instr, 32'h0000_0013);

    // I-type, S-type and SB-type words in sequence.
    do_fetch("i4", 32'd4, 32'h0050_0093);
    check_eq("i4_opcode", {25'b0, Opcode}, 32'h13);
    check_eq("i4_rd", {27'b0, rd}, 32'd1);
    retire(1'b0, 1'b0, 32'h0);
    do_fetch("s8", 32'd8, 32'h0011_2023);
    check_eq("s8_opcode", {25'b0, Opcode}, 32'h23);
    retire(1'b0, 1'b0, 32'h0);
    check_eq("s8_next_pc", pc, 32'd12);
    do_fetch("b12", 32'd12, 32'h0020_8463);
    check_eq("b12_opcode", {25'b0, Opcode}, 32'h63);

    // Taken branch with offset -8 goes from 12 back to 4.
    retire(1'b1, 1'b1, 32'hFFFF_FFF8);
    check_eq("br_taken_pc", pc, 32'd4);
    do_fetch("bt4", 32'd4, 32'h0050_0093);
    retire(1'b0, 1'b0, 32'h0);
    do_fetch("bt8", 32'd8, 32'h0011_2023);
    retire(1'b0, 1'b0, 32'h0);

    // The same branch when it is not taken falls through to 16.
    do_fetch("bn12", 32'd12, 32'h0020_8463);
    retire(1'b1, 1'b0, 32'hFFFF_FFF8);
    do_fetch("bn16", 32'd16, 32'h0020_8463);
    retire(1'b1, 1'b1, 32'hFFFF_FFFC);   // 16 - 4 = 12
    check_eq("pre_mis_flag", {31'b0, misaligned}, 32'd0);

    // Offset 6 gives 18, which is masked to 16 and sets the sticky misaligned flag.
    do_fetch("bm12", 32'd12, 32'h0020_8463);
    retire(1'b1, 1'b1, 32'd6);
    check_eq("mis_pc", pc, 32'd16);
    check_eq("mis_flag", {31'b0, misaligned}, 32'd1);
    do_fetch("bm16", 32'd16, 32'h0033_0333);

    // Hold the stall for five cycles while toggling the branch inputs.
    held_pc    = pc;
    held_instr = instr;
    for (int i = 0; i < 5; i++) begin
      branch        = i[0];
      branch_taken  = 1'b1;
      branch_offset = 32'h40;
      @(negedge clk);
      check_eq($sformatf("stall%0d_pc", i), pc, held_pc);
      check_eq($sformatf("stall%0d_instr", i), instr, held_instr);
      check_eq($sformatf("stall%0d_valid", i), {31'b0, instr_valid}, 32'd1);
    end
    branch = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
    retire(1'b0, 1'b0, 32'h0);
    check_eq("post_stall_pc", pc, 32'd20);
    check_eq("mis_sticky", {31'b0, misaligned}, 32'd1);

    // Keep the memory not ready for four cycles, with a spurious response during FETCH.
    for (int i = 0; i < 4; i++) begin
      imem_resp_valid = (i == 1);
      imem_rdata      = 32'hBAD0_0000;
      @(negedge clk);
      check_eq($sformatf("notrdy%0d_req_valid", i), {31'b0, imem_req_valid}, 32'd1);
      check_eq($sformatf("notrdy%0d_addr", i), imem_addr, 32'd20);
    end
    imem_resp_valid = 1'b0;
    check_eq("spur_fetch_instr", instr, 32'h0000_0013);
    check_eq("spur_fetch_valid", {31'b0, instr_valid}, 32'd0);
    do_fetch("f20", 32'd20, 32'h0050_0093);

    // A spurious response during ISSUE leaves the instruction register unchanged.
    imem_resp_valid = 1'b1; imem_rdata = 32'hBAD1_1111;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    check_eq("spur_issue_instr", instr, 32'h0050_0093);
    retire(1'b0, 1'b0, 32'h0);

    // Assert reset while in WAIT, then send a late response after reset is released.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check_eq("wait_pc", pc, 32'd24);
    reset = 1'b1;
    #1;
    check_eq("async_rst_pc", pc, 32'h0);
    check_eq("async_rst_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imem_resp_valid = 1'b1; imem_rdata = 32'hBAD2_2222;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    check_eq("late_resp_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("late_resp_instr", instr, 32'h0000_0013);
    check_eq("late_resp_pc", pc, 32'h0);
    do_fetch("after_rst", 32'h0, 32'h0033_0333);

    // On the instance with RESET_PC = FFFF_FFFC, one retire wraps the PC to 0.
    check_eq("wrap_req_valid", {31'b0, w_req_valid}, 32'd1);
    check_eq("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b1;
    @(negedge clk);
    w_req_ready = 1'b0; w_resp_valid = 1'b1; w_rdata = 32'h0000_0013;
    @(negedge clk);
    w_resp_valid = 1'b0;
    check_eq("wrap_valid", {31'b0, w_instr_valid}, 32'd1);
    w_stall = 1'b0;
    @(negedge clk);
    w_stall = 1'b1;
    check_eq("wrap_pc", w_pc, 32'h0);
    check_eq("wrap_addr1", w_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit so that the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
